round_robin_arbiter: RTL and testbench
======================================

ROUND_ROBIN_ARBITER -- requirements
Module: round_robin_arbiter

Interface
REQ-001 SHALL have parameter N, default 16: number of requesters; legal range 2..64.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req, input, N bits: bit i high = requester i wants access; level-sensitive, sampled each rising clk edge.
REQ-005 SHALL have port grant, output, N bits: registered, one-hot or all-zero; bit i high = requester i owns the resource this cycle.

Function
REQ-006 SHALL keep an internal priority pointer ptr, width $clog2(N); requester ptr has highest priority, then ptr+1, and so on, wrapping N-1 -> 0.
REQ-007 SHALL, at each rising edge, register in grant the first requester with req set, searching from ptr upward modulo N.
REQ-008 SHALL have a latency of one cycle: req sampled at edge k appears in grant after edge k.
REQ-009 SHALL drive grant = 0 when req = 0, and leave ptr unchanged in that case.
REQ-010 SHALL, when requester g is granted, set ptr to (g+1) mod N in the same edge; g = N-1 wraps ptr to 0.
REQ-011 SHALL never assert more than one grant bit.
REQ-012 SHALL never grant a requester whose req bit was low at the sampling edge.
REQ-013 SHALL re-arbitrate every cycle without configuration option REQ-018: a continuously requesting sole requester is granted every cycle, and k continuous requesters each get one cycle in every k cycles.
REQ-014 SHALL have no handshake beyond req/grant; dropping req mid-grant frees the resource at the next edge.

Reset
REQ-015 SHALL, while rst = 0, force grant = 0 and ptr = 0 immediately, independent of clk.
REQ-016 SHALL resume arbitration at the first rising edge after rst deasserts, with requester 0 highest priority.
REQ-017 SHALL discard any in-progress grant or rotation state when reset asserts mid-operation.

Configuration
REQ-018 SHALL support macro RR_ARB_GRANT_HOLD_EN: when defined, the current grantee keeps grant while its req bit stays high, and ptr advances only when it releases; when undefined, the arbiter behaves per REQ-013.
REQ-019 SHALL, in hold mode, re-arbitrate per REQ-007 at the edge where the grantee's req bit is sampled low, so there is no idle cycle if another request is pending.

Structure
REQ-020 SHALL place in shared package rr_arbiter_pkg the default N constant and a pointer-width helper function (clog2 wrapper).
REQ-021 SHALL implement the combinational rotate/find-first-set search as sub-module rr_priority_picker, with inputs req and ptr and a one-hot output next_grant.
REQ-022 SHALL keep grant and ptr registers in round_robin_arbiter only; the picker is purely combinational.

Verification (N=16, hold macro undefined unless stated)
REQ-023 SHALL be verified by: rst=0 with req=0x0505 -> grant=0x0000 throughout reset; after release, first grant is 0x0001.
REQ-024 SHALL be verified by: req=0x0001 steady -> grant=0x0001 every cycle from the first edge after it is applied.
REQ-025 SHALL be verified by: req=0x0101 steady -> grant alternates 0x0001, 0x0100, 0x0001, and so on. Then req=0x0105 -> grant repeats the rotation 0x0001, 0x0004, 0x0100.
REQ-026 SHALL be verified by: req=0x0505 steady -> grant repeats 0x0001, 0x0004, 0x0100, 0x0400. Then req=0x0000 -> grant=0x0000 one cycle later.
REQ-027 SHALL be verified by: a wrap-around case, req=0x8001 -> grant alternates 0x0001, 0x8000. After granting 0x8000, ptr=0.
REQ-028 SHALL be verified by: with RR_ARB_GRANT_HOLD_EN defined, req=0x0005 -> grant holds 0x0001. Then dropping bit 0 -> grant=0x0004 at the next edge. Then asserting rst mid-hold -> grant=0 asynchronously.

Source files
------------

// File: rtl/rr_arbiter_pkg.sv
// Shared constants and helpers for the round-robin arbiter and its priority picker.
package rr_arbiter_pkg;

    localparam int RR_DEFAULT_N = 16;

    // Pointer width for n requesters; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: one-hot grant for the first requester at or above ptr,
// wrapping to the lowest set request when nothing at or above ptr is requesting.
module rr_priority_picker
    import rr_arbiter_pkg::*;
#(
    parameter int N  = RR_DEFAULT_N,
    parameter int PW = ptr_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  next_grant
);

    logic [N-1:0] hi_mask;
    logic [N-1:0] masked;
    logic [N-1:0] pool;

    assign hi_mask = {N{1'b1}} << ptr;
    assign masked  = req & hi_mask;
    // Requests at or above ptr win; otherwise the search wraps to the full vector.
    assign pool       = (masked != '0) ? masked : req;
    assign next_grant = pool & (~pool + N'(1));

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with registered one-hot grant and rotating priority pointer.
// Optional macro RR_ARB_GRANT_HOLD_EN: current grantee keeps the grant while its request stays high.
module round_robin_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int N = RR_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PW = ptr_width(N);

    logic [PW-1:0]        ptr_q;
    logic [PW-1:0]        ptr_d;
    logic [N-1:0]         grant_q;
    logic [N-1:0]         grant_d;
    logic [N-1:0]         next_grant;
    logic [PW-1:0]        ptr_adv;
    logic [PW-1:0][N-1:0] adv_mask;

    rr_priority_picker #(
        .N  (N),
        .PW (PW)
    ) u_picker (
        .req        (req),
        .ptr        (ptr_q),
        .next_grant (next_grant)
    );

    // Constant table: bit bi of (g+1) mod N for every grantee g, so the one-hot
    // grant converts straight into the next pointer value.
    for (genvar gi = 0; gi < N; gi++) begin : g_adv_row
        for (genvar bi = 0; bi < PW; bi++) begin : g_adv_bit
            assign adv_mask[bi][gi] = 1'(((gi + 1) % N) >> bi);
        end
    end

    for (genvar bi = 0; bi < PW; bi++) begin : g_ptr_adv
        assign ptr_adv[bi] = |(next_grant & adv_mask[bi]);
    end

    always_comb begin
        grant_d = next_grant;
        ptr_d   = (next_grant != '0) ? ptr_adv : ptr_q;
`ifdef RR_ARB_GRANT_HOLD_EN
        if ((grant_q & req) != '0) begin
            grant_d = grant_q;
            ptr_d   = ptr_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant = grant_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Scoreboard bench for round_robin_arbiter (N=16); hold-mode scenario runs when RR_ARB_GRANT_HOLD_EN is defined.
module tb_round_robin_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic [15:0] grant;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];

    // Reference model state
    int          m_ptr;
    logic [15:0] m_grant;

    round_robin_arbiter #(.N(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .grant (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%04h exp=0x%04h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_pick(input logic [15:0] r);
        logic [15:0] v;
        int idx;
`ifdef RR_ARB_GRANT_HOLD_EN
        if ((m_grant & r) != 16'h0) return m_grant;
`endif
        for (int k = 0; k < 16; k++) begin
            idx = (m_ptr + k) % 16;
            if (r[idx]) begin
                v = 16'h0;
                v[idx] = 1'b1;
                return v;
            end
        end
        return 16'h0;
    endfunction

    task automatic model_update(input logic [15:0] g);
        if (g != m_grant || (g != 16'h0)) begin
            for (int i = 0; i < 16; i++) begin
                if (g[i] && g != m_grant) m_ptr = (i + 1) % 16;
`ifndef RR_ARB_GRANT_HOLD_EN
                if (g[i]) m_ptr = (i + 1) % 16;
`endif
            end
        end
        m_grant = g;
    endtask

    // Drive one request vector; expected value is pushed now, checked after the edge.
    task automatic step(input string tag, input logic [15:0] r, input logic [15:0] exp);
        req = r;
        exp_q.push_back(exp);
        model_update(model_pick(r));
        @(posedge clk);
        #1;
        $display("txn %s req=0x%04h grant=0x%04h", tag, r, grant);
        check_eq(tag, grant, exp_q.pop_front());
    endtask

    task automatic step_model(input string tag, input logic [15:0] r);
        logic [15:0] e;
        e = model_pick(r);
        step(tag, r, e);
    endtask

    // Async reset mid-cycle, hold it over two edges, release away from the edge.
    task automatic do_reset(input logic [15:0] r);
        @(posedge clk);
        #3;
        req = r;
        rst = 1'b0;
        #1;
        check_eq("rst_async", grant, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_eq("rst_hold", grant, 16'h0000);
        end
        rst = 1'b1;
        m_ptr = 0;
        m_grant = 16'h0;
    endtask

    initial begin
        rst = 1'b0;
        req = 16'h0505;
        m_ptr = 0;
        m_grant = 16'h0;
        #1;
        check_eq("rst_init", grant, 16'h0000);

        do_reset(16'h0505);
        step("first_grant", 16'h0505, 16'h0001);

`ifdef RR_ARB_GRANT_HOLD_EN
        do_reset(16'h0000);
        for (int i = 0; i < 3; i++) step("hold_0005", 16'h0005, 16'h0001);
        step("hold_release", 16'h0004, 16'h0004);
        step("hold_keep4", 16'h0005, 16'h0004);
        step("hold_keep4b", 16'h0005, 16'h0004);
        #3;
        rst = 1'b0;
        #1;
        check_eq("hold_rst_async", grant, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_ptr = 0;
        m_grant = 16'h0;
`else
        for (int i = 0; i < 4; i++) step("sole_0001", 16'h0001, 16'h0001);

        do_reset(16'h0000);
        for (int i = 0; i < 2; i++) begin
            step("alt_0101_a", 16'h0101, 16'h0001);
            step("alt_0101_b", 16'h0101, 16'h0100);
        end
        for (int i = 0; i < 2; i++) begin
            step("rot_0105_a", 16'h0105, 16'h0001);
            step("rot_0105_b", 16'h0105, 16'h0004);
            step("rot_0105_c", 16'h0105, 16'h0100);
        end

        do_reset(16'h0000);
        step("rot_0505_a", 16'h0505, 16'h0001);
        step("rot_0505_b", 16'h0505, 16'h0004);
        step("rot_0505_c", 16'h0505, 16'h0100);
        step("rot_0505_d", 16'h0505, 16'h0400);
        step("rot_0505_e", 16'h0505, 16'h0001);
        step("rot_0505_f", 16'h0505, 16'h0004);
        step("idle", 16'h0000, 16'h0000);
        step("ptr_kept", 16'h0505, 16'h0100);

        do_reset(16'h0000);
        for (int i = 0; i < 2; i++) begin
            step("wrap_a", 16'h8001, 16'h0001);
            step("wrap_b", 16'h8001, 16'h8000);
        end
        step("wrap_ptr0", 16'hFFFF, 16'h0001);
        step("all_next", 16'hFFFF, 16'h0002);

        // Reset mid-rotation must discard the pointer
        step("pre_rst", 16'hFFFF, 16'h0004);
        do_reset(16'hFFFF);
        step("post_rst", 16'hFFFF, 16'h0001);
`endif

        for (int i = 0; i < 200; i++) begin
            logic [15:0] r;
            r = 16'($urandom) & 16'($urandom);
            if ((i % 17) == 0) r = 16'h0;
            step_model("rand", r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
